// File: rtl/display_timing_pkg.sv
// Raster timing parameter sets shared by display_timings and its users.
package display_timing_pkg;

  // One axis of a raster: active length, porches, sync width and sync level.
  typedef struct packed {
    int   res;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } axis_cfg_t;

  // CEA 1280x720p60, 74.25 MHz pixel clock.
  localparam axis_cfg_t H_720P60 = '{res: 1280, fp: 110, sync: 40, bp: 220, pol: 1'b1};
  localparam axis_cfg_t V_720P60 = '{res: 720,  fp: 5,   sync: 5,  bp: 20,  pol: 1'b1};

  // 640x480p60, 25.175 MHz pixel clock, negative syncs.
  localparam axis_cfg_t H_480P60 = '{res: 640, fp: 16, sync: 96, bp: 48, pol: 1'b0};
  localparam axis_cfg_t V_480P60 = '{res: 480, fp: 10, sync: 2,  bp: 33, pol: 1'b0};

  // Tiny raster for simulation: 25 cycles per line, 8 lines per frame.
  localparam axis_cfg_t H_SIM = '{res: 16, fp: 2, sync: 3, bp: 4, pol: 1'b1};
  localparam axis_cfg_t V_SIM = '{res: 4,  fp: 1, sync: 1, bp: 2, pol: 1'b1};

  // Number of blanking positions before active video on an axis.
  function automatic int axis_blank(input axis_cfg_t c);
    return c.fp + c.sync + c.bp;
  endfunction

  // Full period of an axis in positions (cycles for H, lines for V).
  function automatic int axis_total(input axis_cfg_t c);
    return axis_blank(c) + c.res;
  endfunction

  // True when an axis period fits the signed coordinate range of width w.
  function automatic bit axis_fits(input int total, input int w);
    return total <= (1 << (w - 1));
  endfunction

endpackage

// File: rtl/display_timings_axis.sv
// One raster axis: steps a signed coordinate from STA to END and wraps,
// reporting the next coordinate plus sync and active flags derived from it.
module timing_axis #(
  parameter int                  W    = 16,
  parameter logic signed [W-1:0] STA  = -1,
  parameter int                  FP   = 0,
  parameter int                  SYNC = 1,
  parameter logic signed [W-1:0] END  = 0,
  parameter logic                POL  = 1'b1
) (
  input  logic signed [W-1:0] coord,
  input  logic                inc,
  output logic signed [W-1:0] next,
  output logic                wrap,
  output logic                sync,
  output logic                active
);

  localparam logic signed [W-1:0] ONE        = W'(1);
  localparam logic signed [W-1:0] SYNC_FIRST = W'(int'(STA) + FP);
  localparam logic signed [W-1:0] SYNC_LAST  = W'(int'(STA) + FP + SYNC - 1);

  // Next coordinate and the flags that belong to it, so the registered
  // outputs line up with the registered coordinate.
  always_comb begin
    wrap = inc && (coord == END);
    if (!inc) begin
      next = coord;
    end else if (coord == END) begin
      next = STA;
    end else begin
      next = coord + ONE;
    end
    sync   = (next >= SYNC_FIRST && next <= SYNC_LAST) ? POL : ~POL;
    active = ~next[W-1];
  end

endmodule

// File: rtl/display_timings.sv
// Pixel-domain raster generator: signed beam coordinates (blanking is
// negative, active video is 0..RES-1), syncs, video enable and strobes.
module display_timings
  import display_timing_pkg::*;
#(
  parameter int   COORDSPC = 16,
  parameter int   H_RES    = H_720P60.res,
  parameter int   H_FP     = H_720P60.fp,
  parameter int   H_SYNC   = H_720P60.sync,
  parameter int   H_BP     = H_720P60.bp,
  parameter int   V_RES    = V_720P60.res,
  parameter int   V_FP     = V_720P60.fp,
  parameter int   V_SYNC   = V_720P60.sync,
  parameter int   V_BP     = V_720P60.bp,
  parameter logic H_POL    = H_720P60.pol,
  parameter logic V_POL    = V_720P60.pol
) (
  input  logic                       video_clk_pix,
  input  logic                       video_rst_n,
  output logic signed [COORDSPC-1:0] sx,
  output logic signed [COORDSPC-1:0] sy,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       video_enable,
  output logic                       frame_start,
  output logic                       line_start
);

  localparam logic signed [COORDSPC-1:0] H_STA = COORDSPC'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [COORDSPC-1:0] H_END = COORDSPC'(H_RES - 1);
  localparam logic signed [COORDSPC-1:0] V_STA = COORDSPC'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [COORDSPC-1:0] V_END = COORDSPC'(V_RES - 1);

  // Reject rasters whose period cannot be represented in the signed coordinate.
  if (!axis_fits(H_FP + H_SYNC + H_BP + H_RES, COORDSPC)) begin : g_h_range_err
    $error("display_timings: horizontal period does not fit COORDSPC");
  end
  if (!axis_fits(V_FP + V_SYNC + V_BP + V_RES, COORDSPC)) begin : g_v_range_err
    $error("display_timings: vertical period does not fit COORDSPC");
  end

  logic signed [COORDSPC-1:0] h_next;
  logic signed [COORDSPC-1:0] v_next;
  logic                       h_wrap;
  logic                       v_wrap;
  logic                       h_sync;
  logic                       v_sync;
  logic                       h_active;
  logic                       v_active;

  timing_axis #(
    .W    (COORDSPC),
    .STA  (H_STA),
    .FP   (H_FP),
    .SYNC (H_SYNC),
    .END  (H_END),
    .POL  (H_POL)
  ) u_h_axis (
    .coord  (sx),
    .inc    (1'b1),
    .next   (h_next),
    .wrap   (h_wrap),
    .sync   (h_sync),
    .active (h_active)
  );

  // The vertical axis advances only on the edge where the line wraps, so
  // vsync and the row coordinate change at line boundaries.
  timing_axis #(
    .W    (COORDSPC),
    .STA  (V_STA),
    .FP   (V_FP),
    .SYNC (V_SYNC),
    .END  (V_END),
    .POL  (V_POL)
  ) u_v_axis (
    .coord  (sy),
    .inc    (h_wrap),
    .next   (v_next),
    .wrap   (v_wrap),
    .sync   (v_sync),
    .active (v_active)
  );

  // Register coordinates and flags together; a wrap this cycle means the
  // registered coordinate becomes the start of a line (and of a frame when
  // both axes wrap). Reset parks the beam on the last pixel of a frame so
  // the first edge after release opens a fresh frame.
  always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
    if (!video_rst_n) begin
      sx           <= H_END;
      sy           <= V_END;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      video_enable <= 1'b0;
      frame_start  <= 1'b0;
      line_start   <= 1'b0;
    end else begin
      sx           <= h_next;
      sy           <= v_next;
      hsync        <= h_sync;
      vsync        <= v_sync;
      video_enable <= h_active && v_active;
      frame_start  <= h_wrap && v_wrap;
      line_start   <= h_wrap;
    end
  end

endmodule

// File: tb/tb_display_timings.sv
// Self-checking bench for display_timings on the small simulation raster.
// Expected outputs come from the cycle count since reset release.
module tb_display_timings;
  import display_timing_pkg::*;

  localparam int W      = 16;
  localparam int H_RES  = H_SIM.res;
  localparam int H_FP   = H_SIM.fp;
  localparam int H_SYNC = H_SIM.sync;
  localparam int H_BP   = H_SIM.bp;
  localparam int V_RES  = V_SIM.res;
  localparam int V_FP   = V_SIM.fp;
  localparam int V_SYNC = V_SIM.sync;
  localparam int V_BP   = V_SIM.bp;
  localparam int H_POL  = 1;
  localparam int V_POL  = 1;

  localparam int H_TOT  = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_RES + V_FP + V_SYNC + V_BP;
  localparam int H_STA  = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA  = -(V_FP + V_SYNC + V_BP);
  localparam int H_END  = H_RES - 1;
  localparam int V_END  = V_RES - 1;
  localparam int FRAME  = H_TOT * V_TOT;

  typedef struct {
    int sx;
    int sy;
    int hs;
    int vs;
    int ve;
    int fs;
    int ls;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [W-1:0] sx;
  logic signed [W-1:0] sy;
  logic                hsync;
  logic                vsync;
  logic                video_enable;
  logic                frame_start;
  logic                line_start;

  int asserts  = 0;
  int failures = 0;
  int n        = 0;
  int hrun     = 0;
  int vrun     = 0;
  int fs_cnt   = 0;
  int ls_cnt   = 0;
  bit first_run = 1'b0;

  always #5 clk = ~clk;

  display_timings #(
    .COORDSPC (W),
    .H_RES    (H_RES),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_RES    (V_RES),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_POL    (1'b1),
    .V_POL    (1'b1)
  ) dut (
    .video_clk_pix (clk),
    .video_rst_n   (rst_n),
    .sx            (sx),
    .sy            (sy),
    .hsync         (hsync),
    .vsync         (vsync),
    .video_enable  (video_enable),
    .frame_start   (frame_start),
    .line_start    (line_start)
  );

  task automatic check(input string tag, input int got, input int exp);
    asserts++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: observed %0d, required %0d (cycle %0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  // Raster position n cycles after the first edge following reset release.
  function automatic exp_t model(input int cyc);
    exp_t e;
    int   hi;
    int   vi;
    hi   = cyc % H_TOT;
    vi   = (cyc / H_TOT) % V_TOT;
    e.sx = H_STA + hi;
    e.sy = V_STA + vi;
    e.hs = (e.sx >= H_STA + H_FP && e.sx <= H_STA + H_FP + H_SYNC - 1) ? H_POL : 1 - H_POL;
    e.vs = (e.sy >= V_STA + V_FP && e.sy <= V_STA + V_FP + V_SYNC - 1) ? V_POL : 1 - V_POL;
    e.ve = (e.sx >= 0 && e.sy >= 0) ? 1 : 0;
    e.ls = (hi == 0) ? 1 : 0;
    e.fs = (hi == 0 && vi == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " sx"},           int'(sx),           H_END);
    check({tag, " sy"},           int'(sy),           V_END);
    check({tag, " hsync"},        int'(hsync),        1 - H_POL);
    check({tag, " vsync"},        int'(vsync),        1 - V_POL);
    check({tag, " video_enable"}, int'(video_enable), 0);
    check({tag, " frame_start"},  int'(frame_start),  0);
    check({tag, " line_start"},   int'(line_start),   0);
  endtask

  // One clock of free run, sampled on the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    e = model(n);
    check("sx",           int'(sx),           e.sx);
    check("sy",           int'(sy),           e.sy);
    check("hsync",        int'(hsync),        e.hs);
    check("vsync",        int'(vsync),        e.vs);
    check("video_enable", int'(video_enable), e.ve);
    check("frame_start",  int'(frame_start),  e.fs);
    check("line_start",   int'(line_start),   e.ls);
    if (first_run && n < 200) begin
      fs_cnt += int'(frame_start);
      ls_cnt += int'(line_start);
    end
    if (int'(hsync) == H_POL) begin
      hrun++;
    end else begin
      if (hrun != 0) check("hsync width", hrun, H_SYNC);
      hrun = 0;
    end
    if (int'(vsync) == V_POL) begin
      vrun++;
    end else begin
      if (vrun != 0) check("vsync width", vrun, V_SYNC * H_TOT);
      vrun = 0;
    end
    n++;
  endtask

  // Called just after a falling edge: reset must take effect before the next
  // rising edge, hold through the given cycles, then release.
  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    hrun = 0;
    vrun = 0;
    repeat (hold) @(negedge clk);
    check_reset_values("held reset");
    rst_n = 1'b1;
    n = 0;
  endtask

  initial begin
    int len;
    repeat (5) @(negedge clk);
    check_reset_values("power-on reset");
    rst_n     = 1'b1;
    n         = 0;
    first_run = 1'b1;

    len = 3 * FRAME + int'($urandom_range(0, 50));
    repeat (len) step();
    first_run = 1'b0;
    check("frame_start count in 200", fs_cnt, 1);
    check("line_start count in 200",  ls_cnt, 8);

    apply_reset(int'($urandom_range(1, 4)));

    // Mid-line reset at (4,1).
    while (n <= (1 - V_STA) * H_TOT + (4 - H_STA)) step();
    check("pre-reset sx", int'(sx), 4);
    check("pre-reset sy", int'(sy), 1);
    apply_reset(int'($urandom_range(1, 4)));

    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(1, 3 * FRAME));
      repeat (len) step();
      apply_reset(int'($urandom_range(1, 4)));
    end

    repeat (2 * FRAME + 10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
